// File: rtl/mips_pkg.sv
// Shared MIPS core types: mult/div opcode encoding and the mult/div FSM states.
// Also used by the core decoder.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // True for the four iterative ops (MULT/MULTU/DIV/DIVU); encodings 0..3 all have bit 2 clear.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative mult/div datapath: BITS_PER_CYCLE shift-add
// (multiply) or restoring-subtract (divide) steps on the {acc, q} pair.
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_in  : partial product high half / partial remainder
//   q_in    : multiplier (shifting out) / dividend-quotient (shifting in)
//   b       : multiplicand / divisor magnitude
//   acc_out, q_out : updated pair after BITS_PER_CYCLE steps
module muldiv_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] qq;
  logic [WIDTH:0]   t;

  // Unrolled radix steps; each bit position behaves exactly like a radix-2 step.
  always_comb begin
    a  = acc_in;
    qq = q_in;
    t  = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        // Remainder stays below the divisor, so one conditional subtract suffices.
        t  = {a, qq[WIDTH-1]};
        qq = {qq[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, b}) begin
          t     = t - {1'b0, b};
          qq[0] = 1'b1;
        end
        a = t[WIDTH-1:0];
      end else begin
        // Product low bits enter q from the top as multiplier bits leave the bottom.
        t  = {1'b0, a} + (qq[0] ? {1'b0, b} : (WIDTH+1)'(0));
        qq = {t[0], qq[WIDTH-1:1]};
        a  = t[WIDTH:1];
      end
    end
    acc_out = a;
    q_out   = qq;
  end

endmodule

// File: rtl/mips_muldiv_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
//   clk, reset (sync, active-high), clk_en (global enable, holds everything when low)
//   start, op, rs, rt : issue interface (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   busy              : operation in flight
//   done              : pulse after a mult/div commit (stretches while clk_en is low)
//   hi, lo            : architectural HI/LO
module mips_muldiv_iter
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  muldiv_state_t    state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, b, rs_keep;
  logic             is_div, neg_res, neg_rem, div_zero;

  logic [WIDTH-1:0] acc_step, q_step;
  logic             load, commit, wr_hi, wr_lo;
  logic             signed_op, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

  muldiv_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .q_in    (q),
    .b       (b),
    .acc_out (acc_step),
    .q_out   (q_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Next state and control; any new issue preempts whatever is in flight.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    if (start && is_iter_op(op)) begin
      load      = 1'b1;
      state_nxt = RUN;
    end else if (start && (op == OP_MTHI || op == OP_MTLO)) begin
      wr_hi     = (op == OP_MTHI);
      wr_lo     = (op == OP_MTLO);
      state_nxt = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (cnt == CW'(N - 1)) state_nxt = FIX;
        end
        FIX: begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Operand magnitudes; signed ops work on |rs|, |rt| and fix the sign in FIX.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = signed_op & rs[WIDTH-1];
    sign_b    = signed_op & rt[WIDTH-1];
    mag_a     = sign_a ? -rs : rs;
    mag_b     = sign_b ? -rt : rt;
  end

  // Sign correction and special cases for the value committed on FIX exit.
  always_comb begin
    prod = {acc, q};
    if (neg_res) prod = -prod;
    quo = neg_res ? -q : q;
    rem = neg_rem ? -acc : acc;
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = rs_keep;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Datapath, HI/LO and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      b        <= '0;
      rs_keep  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (clk_en) begin
      busy <= (state_nxt != IDLE);
      done <= commit;
      if (load) begin
        cnt      <= '0;
        acc      <= '0;
        q        <= mag_a;
        b        <= mag_b;
        rs_keep  <= rs;
        is_div   <= op[1];
        neg_res  <= sign_a ^ sign_b;
        neg_rem  <= sign_a;
        div_zero <= op[1] && (rt == '0);
      end else if (state == RUN) begin
        acc <= acc_step;
        q   <= q_step;
        cnt <= cnt + CW'(1);
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (wr_hi) hi <= rs;
      if (wr_lo) lo <= rs;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_iter.sv
// Self-checking bench for mips_muldiv_iter: radix-2 (BPC=1) and radix-16 (BPC=4)
// instances checked against a plain-arithmetic HI/LO model.
module tb_mips_muldiv_iter;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, start_v, sel;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        start1, start4;
  logic        busy1, done1, busy4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;
  logic        busy_s, done_s;
  logic [31:0] hi_s, lo_s;

  int          vec = 0;
  int          errs = 0;
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  always #5 clk = ~clk;

  assign start1 = start_v & ~sel;
  assign start4 = start_v & sel;
  assign busy_s = sel ? busy4 : busy1;
  assign done_s = sel ? done4 : done1;
  assign hi_s   = sel ? hi4 : hi1;
  assign lo_s   = sel ? lo4 : lo1;

  mips_muldiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start1), .op(op),
    .rs(rs), .rt(rt), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  mips_muldiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start4), .op(op),
    .rs(rs), .rt(rt), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4));

  // Architectural result of a mult/div, straight from the ISA definition.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                       output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    int          sa, sb;
    eh = '0;
    el = '0;
    case (o)
      3'd0: begin
        p  = {{32{a[31]}}, a} * {{32{bb[31]}}, bb};
        eh = p[63:32];
        el = p[31:0];
      end
      3'd1: begin
        p  = {32'd0, a} * {32'd0, bb};
        eh = p[63:32];
        el = p[31:0];
      end
      3'd2: begin
        if (bb == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          sa = $signed(a);
          sb = $signed(bb);
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end
      end
      default: begin
        if (bb == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / bb;
          eh = a % bb;
        end
      end
    endcase
  endtask

  // Drive one issue strobe; entered and left on a falling edge.
  task automatic issue(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] bb);
    sel     = s;
    op      = o;
    rs      = a;
    rt      = bb;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
  endtask

  // Issue a mult/div and follow it to done, checking latency, hold and result.
  task automatic run_op(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] bb, input int pause_at, input int pause_len,
                        input string name);
    logic [31:0] eh, el;
    int          cnt, exp_cnt;
    logic        got, held, paused;
    model(o, a, bb, eh, el);
    exp_cnt = (s ? 9 : 33) + pause_len;
    cnt     = 0;
    got     = 1'b0;
    held    = 1'b1;
    paused  = 1'b0;
    issue(s, o, a, bb);
    for (int i = 0; i < 300 && !got; i++) begin
      if (done_s) begin
        got = 1'b1;
      end else begin
        if (busy_s) begin
          cnt++;
          if (hi_s !== m_hi[s] || lo_s !== m_lo[s]) held = 1'b0;
        end
        if (pause_len > 0 && !paused && cnt == pause_at) begin
          paused = 1'b1;
          clk_en = 1'b0;
          repeat (pause_len) begin
            @(negedge clk);
            if (busy_s) cnt++;
          end
          clk_en = 1'b1;
        end
        @(negedge clk);
      end
    end
    vec++;
    if (!got) begin
      errs++;
      $display("FAIL %s timeout: done=%b required=1", name, done_s);
    end
    vec++;
    if (cnt != exp_cnt) begin
      errs++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, cnt, exp_cnt);
    end
    vec++;
    if (!held) begin
      errs++;
      $display("FAIL %s hilo_hold: hi/lo moved while busy, required %h/%h", name, m_hi[s], m_lo[s]);
    end
    vec++;
    if (hi_s !== eh) begin
      errs++;
      $display("FAIL %s hi: got %h required %h", name, hi_s, eh);
    end
    vec++;
    if (lo_s !== el) begin
      errs++;
      $display("FAIL %s lo: got %h required %h", name, lo_s, el);
    end
    m_hi[s] = eh;
    m_lo[s] = el;
    @(negedge clk);
    vec++;
    if (done_s !== 1'b0) begin
      errs++;
      $display("FAIL %s done_width: got %b required 0", name, done_s);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    clk_en  = 1'b1;
    start_v = 1'b0;
    sel     = 1'b0;
    op      = 3'd0;
    rs      = '0;
    rt      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    vec++; if (busy1 !== 1'b0) begin errs++; $display("FAIL reset busy: got %b required 0", busy1); end
    vec++; if (done1 !== 1'b0) begin errs++; $display("FAIL reset done: got %b required 0", done1); end
    vec++; if (hi1 !== 32'd0) begin errs++; $display("FAIL reset hi: got %h required 0", hi1); end
    vec++; if (lo1 !== 32'd0) begin errs++; $display("FAIL reset lo: got %h required 0", lo1); end
    vec++; if (busy4 !== 1'b0 || hi4 !== 32'd0 || lo4 !== 32'd0) begin
      errs++; $display("FAIL reset r16: busy=%b hi=%h lo=%h required 0", busy4, hi4, lo4);
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(1'b0, 3'd0, 32'hFFFF_FFF9, 32'd3, 0, 0, "mult_neg");
    run_op(1'b1, 3'd0, 32'hFFFF_FFF9, 32'd3, 0, 0, "mult_neg_r16");
    run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
    run_op(1'b0, 3'd3, 32'd100, 32'd7, 0, 0, "divu_small");
    run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(1'b0, 3'd3, 32'd5, 32'd0, 0, 0, "divu_zero");
    run_op(1'b0, 3'd2, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_zero");
    run_op(1'b1, 3'd2, 32'h8000_0000, 32'd3, 0, 0, "div_r16");
  endtask

  task automatic test_random();
    int          r;
    logic [2:0]  o;
    logic [31:0] a, bb;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       bb = 32'd0;
        1:       bb = $urandom_range(1, 20);
        2:       bb = -$urandom_range(1, 20);
        default: bb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = -$urandom_range(0, 1000);
      if (r < 8) begin
        o = 3'(r % 4);
        run_op(1'(r % 2), o, a, bb, 0, 0, "random");
      end else if (r == 8) begin
        o = 3'($urandom_range(4, 5));
        issue(1'b0, o, a, bb);
        if (o == 3'd4) m_hi[0] = a; else m_lo[0] = a;
        vec++;
        if (hi1 !== m_hi[0] || lo1 !== m_lo[0] || busy1 !== 1'b0) begin
          errs++;
          $display("FAIL mt_idle: hi=%h lo=%h busy=%b required %h %h 0", hi1, lo1, busy1, m_hi[0], m_lo[0]);
        end
      end else begin
        o = 3'($urandom_range(6, 7));
        issue(1'b0, o, a, bb);
        vec++;
        if (hi1 !== m_hi[0] || lo1 !== m_lo[0] || busy1 !== 1'b0 || done1 !== 1'b0) begin
          errs++;
          $display("FAIL reserved_op: hi=%h lo=%h busy=%b required %h %h 0", hi1, lo1, busy1, m_hi[0], m_lo[0]);
        end
      end
    end
  endtask

  task automatic test_mt_abort();
    logic seen;
    issue(1'b0, 3'd2, $urandom, 32'd7);
    repeat (9) @(negedge clk);
    issue(1'b0, 3'd4, 32'h0000_1234, 32'd0);
    m_hi[0] = 32'h0000_1234;
    vec++; if (hi1 !== 32'h0000_1234) begin errs++; $display("FAIL mthi_abort hi: got %h required 00001234", hi1); end
    vec++; if (lo1 !== m_lo[0]) begin errs++; $display("FAIL mthi_abort lo: got %h required %h", lo1, m_lo[0]); end
    vec++; if (busy1 !== 1'b0) begin errs++; $display("FAIL mthi_abort busy: got %b required 0", busy1); end
    seen = 1'b0;
    repeat (40) begin
      if (done1) seen = 1'b1;
      @(negedge clk);
    end
    vec++; if (seen) begin errs++; $display("FAIL mthi_abort done: got 1 required 0"); end
    issue(1'b0, 3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (4) @(negedge clk);
    run_op(1'b0, 3'd1, 32'h0BAD_F00D, 32'h0000_0101, 0, 0, "multu_restart");
  endtask

  task automatic test_clk_en();
    run_op(1'b0, 3'd2, $urandom, 32'h0000_1F3D, 10, 5, "clken_div");
    run_op(1'b1, 3'd0, $urandom, $urandom, 3, 5, "clken_mult_r16");
  endtask

  task automatic test_reset_mid();
    logic seen;
    issue(1'b0, 3'd0, $urandom, $urandom);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi[0] = '0;
    m_lo[0] = '0;
    vec++; if (busy1 !== 1'b0 || hi1 !== 32'd0 || lo1 !== 32'd0) begin
      errs++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0", busy1, hi1, lo1);
    end
    seen = 1'b0;
    repeat (50) begin
      if (done1) seen = 1'b1;
      @(negedge clk);
    end
    vec++; if (seen) begin errs++; $display("FAIL reset_mid done: got 1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_abort();
    test_clk_en();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
